// File: rtl/is_fu_issue_queue_pkg.sv
// is_fu_issue_queue_pkg: shared sizing, packet types and FU classes for the issue stage
package is_fu_issue_queue_pkg;
  localparam int IQ_DEPTH = 8;
  localparam int ISSUE_WIDTH = 3;
  localparam int NUM_ALU = 3;
  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = $clog2(IQ_DEPTH + 1);
  localparam int IW_W = $clog2(ISSUE_WIDTH + 1);
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } ALU_FUNC;
  typedef enum logic [1:0] {FU_ALU, FU_MULT, FU_MEM} FU_TYPE;
  typedef struct packed {
    logic       valid;
    logic       rd_mem;
    logic       wr_mem;
    ALU_FUNC    alu_func;
    logic [7:0] tag;
  } DP_IS_PACKET;
  typedef struct packed {
    DP_IS_PACKET pkt;
    FU_TYPE      fu;
  } IQ_ENTRY;
  typedef struct packed {
    logic [CNT_W-1:0] free_slots;
  } IS_RS_PACKET;
endpackage

// File: rtl/is_fu_classify.sv
// is_fu_classify: maps one dispatched op to the functional-unit class that executes it
//   rd_mem_i/wr_mem_i/alu_func_i : op attributes   fu_o : MEM, MULT or ALU (default)
module is_fu_classify
  import is_fu_issue_queue_pkg::*;
(
  input  logic    rd_mem_i,
  input  logic    wr_mem_i,
  input  ALU_FUNC alu_func_i,
  output FU_TYPE  fu_o
);
  assign fu_o = (rd_mem_i | wr_mem_i) ? FU_MEM :
                (alu_func_i inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) ? FU_MULT : FU_ALU;
endmodule

// File: rtl/is_fu_issue_queue.sv
// is_fu_issue_queue: in-order circular issue queue routing ops to ALUs, one multiplier and one blocking LSU
//   clock, reset (sync, active-low), squash_flag : control
//   rs_packet_in[3], mult_stall, mem_done        : RS packets and FU back-pressure
//   is_rs_out (free-slot credit), alu/mult/mem_packet_out (registered), overflow_err (sticky)
//   IS_BYPASS_EN: when the queue is empty, arriving packets compete for issue in their arrival cycle
module is_fu_issue_queue
  import is_fu_issue_queue_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        squash_flag,
  input  DP_IS_PACKET rs_packet_in [ISSUE_WIDTH],
  input  logic        mult_stall,
  input  logic        mem_done,
  output IS_RS_PACKET is_rs_out,
  output DP_IS_PACKET alu_packet_out [NUM_ALU],
  output DP_IS_PACKET mult_packet_out,
  output DP_IS_PACKET mem_packet_out,
  output logic        overflow_err
);
  IQ_ENTRY iq_q [IQ_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, free;
  logic mem_busy_q, ovf_q, byp, mem_iss, mult_u, blk, ok;
  DP_IS_PACKET alu_q [NUM_ALU], alu_d [NUM_ALU], mult_q, mult_d, mem_q, mem_d;
  FU_TYPE fu_in [ISSUE_WIDTH];
  IQ_ENTRY in_c [ISSUE_WIDTH], cand [ISSUE_WIDTH], enq_e [ISSUE_WIDTH];
  logic [IW_W-1:0] n_in, n_acc, cand_n, n_iss, n_enq, n_deq, alu_n, skip;
  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_cls
    is_fu_classify u_cls (
      .rd_mem_i  (rs_packet_in[i].rd_mem),
      .wr_mem_i  (rs_packet_in[i].wr_mem),
      .alu_func_i(rs_packet_in[i].alu_func),
      .fu_o      (fu_in[i])
    );
  end
  assign free = CNT_W'(IQ_DEPTH) - count_q;
`ifdef IS_BYPASS_EN
  assign byp = count_q == '0;
`else
  assign byp = 1'b0;
`endif
  always_comb begin
    n_in = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) in_c[i] = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++)
      if (rs_packet_in[i].valid) begin
        in_c[n_in] = '{pkt: rs_packet_in[i], fu: fu_in[i]};
        n_in = n_in + IW_W'(1);
      end
    n_acc = (CNT_W'(n_in) > free) ? IW_W'(free) : n_in;
  end
  // oldest-first selection; the first op that cannot go blocks all younger ones
  always_comb begin
    for (int j = 0; j < ISSUE_WIDTH; j++) cand[j] = byp ? in_c[j] : iq_q[head_q + PTR_W'(j)];
    cand_n = byp ? n_in : (count_q >= CNT_W'(ISSUE_WIDTH) ? IW_W'(ISSUE_WIDTH) : IW_W'(count_q));
    for (int j = 0; j < NUM_ALU; j++) alu_d[j] = '0;
    mult_d = '0;
    mem_d = '0;
    n_iss = '0;
    alu_n = '0;
    blk = 1'b0;
    ok = 1'b0;
    mult_u = 1'b0;
    mem_iss = 1'b0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      ok = !blk && IW_W'(j) < cand_n &&
           (cand[j].fu == FU_ALU  ? alu_n < IW_W'(NUM_ALU) :
            cand[j].fu == FU_MULT ? !mult_stall && !mult_u : !mem_busy_q && !mem_iss);
      blk = !ok;
      if (ok && cand[j].fu == FU_ALU) begin
        alu_d[alu_n] = cand[j].pkt;
        alu_n = alu_n + IW_W'(1);
      end
      if (ok && cand[j].fu == FU_MULT) begin
        mult_d = cand[j].pkt;
        mult_u = 1'b1;
      end
      if (ok && cand[j].fu == FU_MEM) begin
        mem_d = cand[j].pkt;
        mem_iss = 1'b1;
      end
      n_iss = n_iss + IW_W'(ok);
    end
    // bypassed ops never occupy the queue, so only the remainder is written
    skip = byp ? n_iss : '0;
    n_deq = byp ? '0 : n_iss;
    n_enq = n_acc - skip;
    for (int i = 0; i < ISSUE_WIDTH; i++) enq_e[i] = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++)
      if (IW_W'(i) >= skip) enq_e[IW_W'(i) - skip] = in_c[i];
  end
  always_ff @(posedge clock) begin
    if (!reset || squash_flag) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      mem_busy_q <= 1'b0;
      for (int j = 0; j < NUM_ALU; j++) alu_q[j] <= '0;
      mult_q <= '0;
      mem_q <= '0;
    end else begin
      for (int k = 0; k < ISSUE_WIDTH; k++)
        if (IW_W'(k) < n_enq) iq_q[tail_q + PTR_W'(k)] <= enq_e[k];
      head_q <= head_q + PTR_W'(n_deq);
      tail_q <= tail_q + PTR_W'(n_enq);
      count_q <= count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
      mem_busy_q <= mem_iss || (mem_busy_q && !mem_done);
      alu_q <= alu_d;
      mult_q <= mult_d;
      mem_q <= mem_d;
    end
    if (!reset) ovf_q <= 1'b0;
    else if (!squash_flag && CNT_W'(n_in) > free) ovf_q <= 1'b1;
  end
  assign is_rs_out.free_slots = free;
  assign alu_packet_out = alu_q;
  assign mult_packet_out = mult_q;
  assign mem_packet_out = mem_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_is_fu_issue_queue.sv
// tb_is_fu_issue_queue: directed stimulus with a cycle-tagged scoreboard checked by an output monitor
module tb_is_fu_issue_queue;
  import is_fu_issue_queue_pkg::*;
`ifdef IS_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  typedef struct {
    int         cyc;
    int         port;
    logic [7:0] tag;
  } exp_t;
  logic clock = 1'b0, reset = 1'b0, squash_flag = 1'b0, mult_stall = 1'b0, mem_done = 1'b0;
  logic overflow_err;
  DP_IS_PACKET rs_in [ISSUE_WIDTH];
  DP_IS_PACKET alu_out [NUM_ALU];
  DP_IS_PACKET mult_out, mem_out, mon_o;
  IS_RS_PACKET rs_out;
  exp_t sb[$];
  exp_t mon_e;
  int total = 0, bad = 0, cyc = 0;
  is_fu_issue_queue dut (
    .clock          (clock),
    .reset          (reset),
    .squash_flag    (squash_flag),
    .rs_packet_in   (rs_in),
    .mult_stall     (mult_stall),
    .mem_done       (mem_done),
    .is_rs_out      (rs_out),
    .alu_packet_out (alu_out),
    .mult_packet_out(mult_out),
    .mem_packet_out (mem_out),
    .overflow_err   (overflow_err)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask
  function automatic DP_IS_PACKET op(input int kind, input logic [7:0] tag);
    DP_IS_PACKET p;
    p = '0;
    p.valid = 1'b1;
    p.tag = tag;
    p.rd_mem = kind == 2;
    p.wr_mem = kind == 3;
    if (kind == 1) p.alu_func = ALU_MUL;
    else if (kind == 4) p.alu_func = ALU_MULHU;
    else p.alu_func = ALU_ADD;
    return p;
  endfunction
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input DP_IS_PACKET a, input DP_IS_PACKET b, input DP_IS_PACKET c);
    rs_in[0] = a;
    rs_in[1] = b;
    rs_in[2] = c;
  endtask
  task automatic idle();
    send('0, '0, '0);
  endtask
  task automatic expect_out(input int c, input int port, input logic [7:0] tag);
    sb.push_back('{c, port, tag});
  endtask
  // ports 0..2 = ALU, 3 = MULT, 4 = MEM; expectations are queued in that order per cycle
  always @(negedge clock)
    for (int p = 0; p < 5; p++) begin
      mon_o = p < 3 ? alu_out[p] : (p == 3 ? mult_out : mem_out);
      if (mon_o.valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_issue cyc=%0d port=%0d tag=%0h want=none", cyc, p, mon_o.tag);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.cyc != cyc || mon_e.port != p || mon_e.tag != mon_o.tag) begin
            bad++;
            $display("FAIL issue cyc/port/tag got=%0d/%0d/%0h want=%0d/%0d/%0h",
                     cyc, p, mon_o.tag, mon_e.cyc, mon_e.port, mon_e.tag);
          end
        end
      end
    end
  initial begin
    int n, v, s;
    idle();
    repeat (2) step();
    @(negedge clock);
    chk("rst_free", int'(rs_out.free_slots), 8);
    chk("rst_ovf", int'(overflow_err), 0);
    chk("rst_valid", int'({alu_out[0].valid, alu_out[1].valid, alu_out[2].valid, mult_out.valid, mem_out.valid}), 0);
    step();
    reset = 1'b1;
    step();
    n = cyc;
    send(op(0, 8'h10), op(0, 8'h11), op(0, 8'h12));
    expect_out(n + LAT, 0, 8'h10);
    expect_out(n + LAT, 1, 8'h11);
    expect_out(n + LAT, 2, 8'h12);
    step();
    idle();
    @(negedge clock);
    chk("credit_lag", int'(rs_out.free_slots), LAT == 2 ? 5 : 8);
    repeat (2) step();
    @(negedge clock);
    chk("credit_back", int'(rs_out.free_slots), 8);
    step();
    n = cyc;
    v = n + LAT;
    send(op(2, 8'h20), op(2, 8'h21), op(0, 8'h22));
    expect_out(v, 4, 8'h20);
    expect_out(v + 4, 0, 8'h22);
    expect_out(v + 4, 4, 8'h21);
    step();
    idle();
    while (cyc < v + 2) step();
    @(negedge clock);
    chk("mem_block_hold", int'(rs_out.free_slots), 6);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    while (cyc < v + 5) step();
    @(negedge clock);
    chk("mem_drain", int'(rs_out.free_slots), 8);
    step();
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    step();
    mult_stall = 1'b1;
    send(op(4, 8'h30), op(0, 8'h31), op(0, 8'h32));
    step();
    idle();
    repeat (3) step();
    @(negedge clock);
    chk("stall_hold", int'(rs_out.free_slots), 5);
    step();
    s = cyc;
    mult_stall = 1'b0;
    expect_out(s + 1, 0, 8'h31);
    expect_out(s + 1, 1, 8'h32);
    expect_out(s + 1, 3, 8'h30);
    step();
    @(negedge clock);
    chk("stall_release", int'(rs_out.free_slots), 8);
    step();
    squash_flag = 1'b1;
    step();
    squash_flag = 1'b0;
    mult_stall = 1'b1;
    send(op(1, 8'h40), op(0, 8'h41), op(0, 8'h42));
    step();
    send(op(0, 8'h43), op(0, 8'h44), op(0, 8'h45));
    step();
    send('0, op(0, 8'h46), '0);
    step();
    send(op(0, 8'h47), op(0, 8'h48), op(0, 8'h49));
    @(negedge clock);
    chk("near_full", int'(rs_out.free_slots), 1);
    chk("no_ovf_yet", int'(overflow_err), 0);
    step();
    idle();
    @(negedge clock);
    chk("full", int'(rs_out.free_slots), 0);
    chk("ovf_set", int'(overflow_err), 1);
    step();
    s = cyc;
    mult_stall = 1'b0;
    expect_out(s + 1, 0, 8'h41);
    expect_out(s + 1, 1, 8'h42);
    expect_out(s + 1, 3, 8'h40);
    expect_out(s + 2, 0, 8'h43);
    expect_out(s + 2, 1, 8'h44);
    expect_out(s + 2, 2, 8'h45);
    expect_out(s + 3, 0, 8'h46);
    expect_out(s + 3, 1, 8'h47);
    repeat (3) step();
    @(negedge clock);
    chk("wrap_drain", int'(rs_out.free_slots), 8);
    chk("ovf_sticky", int'(overflow_err), 1);
    step();
    n = cyc;
    send(op(2, 8'h50), '0, '0);
    expect_out(n + LAT, 4, 8'h50);
    step();
    send(op(2, 8'h51), op(0, 8'h52), op(0, 8'h53));
    step();
    send(op(0, 8'h54), op(0, 8'h55), '0);
    step();
    send(op(0, 8'h56), op(0, 8'h57), op(0, 8'h58));
    squash_flag = 1'b1;
    @(negedge clock);
    chk("pre_squash", int'(rs_out.free_slots), 3);
    step();
    idle();
    squash_flag = 1'b0;
    @(negedge clock);
    chk("squash_free", int'(rs_out.free_slots), 8);
    chk("squash_valid", int'({alu_out[0].valid, alu_out[1].valid, alu_out[2].valid, mult_out.valid, mem_out.valid}), 0);
    step();
    s = cyc;
    send(op(3, 8'h59), '0, '0);
    expect_out(s + LAT, 4, 8'h59);
    step();
    idle();
    repeat (4) step();
    @(negedge clock);
    chk("post_squash_free", int'(rs_out.free_slots), 8);
    chk("ovf_survives_squash", int'(overflow_err), 1);
    step();
    send(op(0, 8'h60), op(0, 8'h61), '0);
    reset = 1'b0;
    step();
    idle();
    reset = 1'b1;
    @(negedge clock);
    chk("rst_ovf_clr", int'(overflow_err), 0);
    chk("rst_free2", int'(rs_out.free_slots), 8);
    repeat (4) step();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
